// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
// Main control FSM for the multicycle ARMv4 datapath. Each instruction is
// walked through fetch, decode, execute, memory and writeback. The FSM emits
// the datapath mux selects and the raw write requests. The conditional
// execution stage gates those requests with the flags downstream.
// A retired-instruction counter is kept for debug.
//
// Optional feature macro: MEM_WAIT_EN
//   When defined, a mem_ready input is added after Funct.
//   FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
//   IRWrite, NextPC and MemW are only asserted on the ready cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Op[1:0]           instr[27:26]
//   Funct[5:0]        instr[25:20] (I, cmd[3:0], S/L)
//   mem_ready         memory handshake (MEM_WAIT_EN only)
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc   datapath controls
//   NextPC, RegW, MemW, Branch                            raw write requests
//   undef             sticky undefined-instruction flag
//   instr_count       retired-instruction count (CNT_W bits, wraps)
//   state             current state encoding (STATE_W bits)

module arm_multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
`ifdef MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ALUOp,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               undef,
  output logic [CNT_W-1:0]   instr_count,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       aluop;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  state_t     cur;
  state_t     nxt;
  ctrl_t      ctrl_q;
  logic       undef_q;
  logic [CNT_W-1:0] cnt;
  logic       ready;
  logic       retire;

`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Moore control decode for a given state.
  // Compare-type ops (TST/TEQ/CMP/CMN, cmd 10xx) only update flags.
  // For those ops, ALUWB suppresses the register write.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      MEMADR:   c.alusrcb = 2'b01;
      MEMREAD:  c.adrsrc  = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regw      = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      EXECUTER: c.aluop = 1'b1;
      EXECUTEI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 1'b1;
      end
      ALUWB:    c.regw = (f[4:3] != 2'b10);
      BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.branch    = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection. Memory-facing states stall while memory is not ready.
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:    nxt = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = UNKNOWN;
        endcase
      end
      MEMADR:   nxt = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = FETCH;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BRANCH:   nxt = FETCH;
      UNKNOWN:  nxt = UNKNOWN;
      default:  nxt = UNKNOWN;
    endcase
    if (!ready && (cur == FETCH || cur == MEMREAD || cur == MEMWRITE))
      nxt = cur;
  end

  // An instruction retires on the clock that leaves its final state.
  assign retire = (cur == MEMWB) || (cur == ALUWB) || (cur == BRANCH) ||
                  ((cur == MEMWRITE) && ready);

  // State, registered controls, sticky undef flag and retire counter.
  // Controls are decoded from the next state, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= FETCH;
      ctrl_q  <= decode(FETCH, Funct);
      undef_q <= 1'b0;
      cnt     <= '0;
    end else begin
      cur    <= nxt;
      ctrl_q <= decode(nxt, Funct);
      if (nxt == UNKNOWN)
        undef_q <= 1'b1;
      if (retire)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Reset overrides every output.
  // One-shot requests are qualified by ready, so a stalled cycle never repeats them.
  assign IRWrite     = ~rst & ctrl_q.irwrite & ready;
  assign NextPC      = ~rst & ctrl_q.nextpc & ready;
  assign MemW        = ~rst & ctrl_q.memw & ready;
  assign AdrSrc      = ~rst & ctrl_q.adrsrc;
  assign ALUSrcA     = ~rst & ctrl_q.alusrca;
  assign ALUSrcB     = rst ? 2'b00 : ctrl_q.alusrcb;
  assign ALUOp       = ~rst & ctrl_q.aluop;
  assign ResultSrc   = rst ? 2'b00 : ctrl_q.resultsrc;
  assign RegW        = ~rst & ctrl_q.regw;
  assign Branch      = ~rst & ctrl_q.branch;
  assign undef       = ~rst & undef_q;
  assign instr_count = rst ? '0 : cnt;
  assign state       = rst ? '0 : STATE_W'(cur);

endmodule
